alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter: W, 16, datapath width.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: instr_valid  input  1  instruction offered.
REQ-005 SHALL have port: instr_ready  output  1  controller can accept.
REQ-006 SHALL have port: instr  input  16  [15:11] opcode, [10:9] dst sel, [8:7] src sel, [6] use_imm, [5:0] reserved.
REQ-007 SHALL have port: imm  input  W  immediate operand B.
REQ-008 SHALL have ports: alu_op  output  5;  alu_a  output  W;  alu_b  output  W  (drive the external ALU).
REQ-009 SHALL have ports: alu_result  input  W;  alu_address  input  2;  alu_flags  input  4  {N,Z,C,V}, combinational ALU returns.
REQ-010 SHALL have ports: acc, x, y  output  W each  architectural registers.
REQ-011 SHALL have port: flags  output  4  registered {N,Z,C,V}.
REQ-012 SHALL have ports: done  output  1  one-cycle completion pulse; err  output  1  one-cycle error pulse.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; instr_ready = (state==IDLE), combinational.
REQ-014 SHALL, on instr_valid & instr_ready, latch instr and imm and go to EXEC; otherwise stay in IDLE.
REQ-015 SHALL, in EXEC, drive alu_op = latched opcode, alu_a = register at dst sel, alu_b = imm if use_imm else register at src sel; sel codes 00 acc, 01 x, 10 y, 11 reads 0.
REQ-016 SHALL, for MOV (5'b00100), drive alu_a = {0, dst sel} and write alu_result to the register named by alu_address.
REQ-017 SHALL, at the EXEC->WB edge, write alu_result to dst register for ADD..XOR, NOT, INC, DEC (5'b00000-5'b01101 excl. MOV, 5'b10000, 5'b10001).
REQ-018 SHALL, for CMP (5'b01110) and TST (5'b01111), update flags only; no register write.
REQ-019 SHALL, at the same edge, load flags from alu_flags for every legal opcode.
REQ-020 SHALL treat opcodes 5'b10010-5'b11111 as illegal: no register/flag write, err=1 in WB.
REQ-021 SHALL pulse done=1 for exactly the WB cycle, for legal and illegal instructions alike.
REQ-022 SHALL drive alu_op, alu_a, alu_b to 0 outside EXEC.
REQ-023 SHALL give throughput of one instruction per 3 cycles; accept at edge k, writeback at edge k+1, done high in cycle after k+1.
REQ-024 SHALL ignore instr and imm changes after acceptance; dst sel 11 writes discard.

Reset
REQ-025 SHALL, on rst high at a clock edge, set state IDLE, acc=x=y=0, flags=4'b0000, done=0, err=0, latched instr=0.
REQ-026 SHALL abort an in-flight instruction on reset mid-EXEC or mid-WB with no writeback and no done pulse.
REQ-027 SHALL hold instr_ready=1 during and after reset (state IDLE), but SHALL NOT accept while rst is high.

Configuration
REQ-028 SHALL, with ALU_CTRL_DIVZERO_TRAP_EN defined, treat DIV (5'b01000) or MOD (5'b01001) with alu_b==0 as faulting: no register/flag write, err=1 and done=1 in WB.
REQ-029 SHALL, without ALU_CTRL_DIVZERO_TRAP_EN, write alu_result and alu_flags unchanged for zero divisors.

Structure
REQ-030 SHALL take opcode constants, register-select codes (ACC 2'b00, X 2'b01, Y 2'b10) and FSM state encoding from shared package alu_pkg, also used by the ALU.
REQ-031 SHALL place opcode classification (legal, writes_reg, flags_only, is_mov, is_divmod) in one combinational sub-module alu_ctrl_decode.
REQ-032 SHALL NOT instantiate the ALU; the ALU connects at the parent level.

Verification
REQ-033 SHALL cover: reset, MOV imm 16'h0005 to X (opcode 00100, dst 01, use_imm) -> x=16'h0005, done in cycle 3, acc/y unchanged.
REQ-034 SHALL cover: acc=16'h7FFF, ADD imm 16'h0001 to acc -> acc=16'h8000, flags N=1,Z=0,V=1.
REQ-035 SHALL cover: acc=16'h0003, CMP imm 16'h0003 -> acc unchanged, flags Z=1.
REQ-036 SHALL cover: opcode 5'b11111 -> no writes, err=1 and done=1 same cycle, flags unchanged.
REQ-037 SHALL cover: x=16'h0010, DIV imm 0 -> with macro err=1 and x stays 16'h0010; without macro x takes alu_result.
REQ-038 SHALL cover: rst asserted in EXEC of ADD acc,1 -> acc=0, no done, instr_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU controller and the external ALU.
//   - Opcode encodings (5-bit), with the last legal opcode marking the legal range.
//   - Register-select codes for the dst/src fields of an instruction.
//   - Controller FSM state encoding.
package alu_pkg;

    // Opcodes the controller treats specially; the rest of 5'b00000-5'b10001 are
    // plain register-writing ALU operations.
    localparam logic [4:0] OpAdd       = 5'b00000;
    localparam logic [4:0] OpMov       = 5'b00100;
    localparam logic [4:0] OpDiv       = 5'b01000;
    localparam logic [4:0] OpMod       = 5'b01001;
    localparam logic [4:0] OpCmp       = 5'b01110;
    localparam logic [4:0] OpTst       = 5'b01111;
    localparam logic [4:0] OpLastLegal = 5'b10001;

    // Register-select codes; SelZero reads as 0 and discards writes.
    localparam logic [1:0] SelAcc  = 2'b00;
    localparam logic [1:0] SelX    = 2'b01;
    localparam logic [1:0] SelY    = 2'b10;
    localparam logic [1:0] SelZero = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StWb   = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational opcode classification for the ALU controller.
// Ports:
//   opcode_i      5-bit opcode
//   legal_o       opcode is in the legal range
//   writes_reg_o  result goes to the dst register (excludes MOV, CMP, TST)
//   flags_only_o  CMP/TST: flags update only
//   is_mov_o      MOV: result written to the register named by the ALU
//   is_divmod_o   DIV or MOD
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic       legal_o,
    output logic       writes_reg_o,
    output logic       flags_only_o,
    output logic       is_mov_o,
    output logic       is_divmod_o
);

    always_comb begin
        legal_o      = (opcode_i <= OpLastLegal);
        is_mov_o     = (opcode_i == OpMov);
        flags_only_o = (opcode_i == OpCmp) || (opcode_i == OpTst);
        is_divmod_o  = (opcode_i == OpDiv) || (opcode_i == OpMod);
        writes_reg_o = legal_o && !flags_only_o && !is_mov_o;
    end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: three-state (IDLE -> EXEC -> WB) controller that sequences one
// instruction at a time through an external combinational ALU and owns the
// architectural registers acc, x, y and the {N,Z,C,V} flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr, imm               instruction word and immediate operand B
//   alu_op/alu_a/alu_b       ALU drive, non-zero only in EXEC
//   alu_result/alu_address/alu_flags  combinational ALU returns
//   acc, x, y, flags         architectural state
//   done, err                one-cycle pulses during WB
// Configuration:
//   ALU_CTRL_DIVZERO_TRAP_EN  when defined, DIV/MOD with a zero divisor faults
//                             (no writes, err=1) instead of committing.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [15:0]  instr,
    input  logic [W-1:0] imm,
    output logic [4:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result,
    input  logic [1:0]   alu_address,
    input  logic [3:0]   alu_flags,
    output logic [W-1:0] acc,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic [3:0]   flags,
    output logic         done,
    output logic         err
);

    alu_state_e   state_q;
    // Only instr[15:6] carries meaning; the reserved low bits are not kept.
    logic [15:6]  instr_q;
    logic [W-1:0] imm_q;
    logic [W-1:0] acc_q, x_q, y_q;
    logic [3:0]   flags_q;
    logic         done_q, err_q;

    logic [4:0]   opcode;
    logic [1:0]   dst_sel, src_sel;
    logic         use_imm;
    logic         legal, writes_reg, flags_only, is_mov, is_divmod;
    logic [W-1:0] dst_val, src_val;
    logic         div_fault, commit, wr_en;
    logic [1:0]   wr_sel;

    assign opcode  = instr_q[15:11];
    assign dst_sel = instr_q[10:9];
    assign src_sel = instr_q[8:7];
    assign use_imm = instr_q[6];

    alu_ctrl_decode u_decode (
        .opcode_i     (opcode),
        .legal_o      (legal),
        .writes_reg_o (writes_reg),
        .flags_only_o (flags_only),
        .is_mov_o     (is_mov),
        .is_divmod_o  (is_divmod)
    );

    // Register file read ports.
    always_comb begin
        dst_val = '0;
        case (dst_sel)
            SelAcc:  dst_val = acc_q;
            SelX:    dst_val = x_q;
            SelY:    dst_val = y_q;
            default: dst_val = '0;
        endcase
        src_val = '0;
        case (src_sel)
            SelAcc:  src_val = acc_q;
            SelX:    src_val = x_q;
            SelY:    src_val = y_q;
            default: src_val = '0;
        endcase
    end

    // ALU drive; MOV passes the destination code on A so the ALU can echo it
    // back on alu_address.
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        if (state_q == StExec) begin
            alu_op = opcode;
            alu_a  = is_mov ? {{(W-2){1'b0}}, dst_sel} : dst_val;
            alu_b  = use_imm ? imm_q : src_val;
        end
    end

`ifdef ALU_CTRL_DIVZERO_TRAP_EN
    assign div_fault = is_divmod && (alu_b == '0);
`else
    assign div_fault = is_divmod && 1'b0;
`endif

    assign commit = legal && !div_fault;
    assign wr_en  = commit && (writes_reg || is_mov);
    assign wr_sel = is_mov ? alu_address : dst_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            instr_q <= '0;
            imm_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (instr_valid) begin
                        instr_q <= instr[15:6];
                        imm_q   <= imm;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (wr_en) begin
                        case (wr_sel)
                            SelAcc:  acc_q <= alu_result;
                            SelX:    x_q   <= alu_result;
                            SelY:    y_q   <= alu_result;
                            default: ;
                        endcase
                    end
                    if (commit) begin
                        flags_q <= alu_flags;
                    end
                    done_q  <= 1'b1;
                    err_q   <= !commit;
                    state_q <= StWb;
                end
                StWb: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign instr_ready = (state_q == StIdle);
    assign acc         = acc_q;
    assign x           = x_q;
    assign y           = y_q;
    assign flags       = flags_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed bench for alu_ctrl with a behavioural ALU stub, an
// instruction-level reference model and a per-cycle compare process.
module tb_alu_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [15:0]  instr;
    logic [W-1:0] imm;
    logic [4:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [1:0]   alu_address;
    logic [3:0]   alu_flags;
    logic [W-1:0] acc, x, y;
    logic [3:0]   flags;
    logic         done, err;

    always #5 clk = ~clk;

    alu_ctrl #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_address (alu_address),
        .alu_flags   (alu_flags),
        .acc         (acc),
        .x           (x),
        .y           (y),
        .flags       (flags),
        .done        (done),
        .err         (err)
    );

    // Behavioural ALU: returns {address, N, Z, C, V, result}.
    function automatic logic [21:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, v;
        r = a ^ b ^ 16'h5A5A;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            5'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'd1, 5'd14: begin
                r = a - b;
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'd2, 5'd15: r = a & b;
            5'd3:        r = a | b;
            5'd4:        r = b;
            5'd5:        r = a ^ b;
            5'd8:        r = (b == 16'h0) ? 16'hFFFF : a / b;
            5'd9:        r = (b == 16'h0) ? a : a % b;
            5'd16:       r = ~a;
            5'd17:       r = a + 16'h1;
            default:     ;
        endcase
        return {a[1:0], r[15], (r == 16'h0), c, v, r};
    endfunction

    always_comb begin
        {alu_address, alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b);
    end

    // Reference model state and expected outputs.
    logic [15:0] m_reg [4];
    logic [3:0]  m_flags;
    logic        exp_ready, exp_done, exp_err;
    logic [4:0]  exp_op;
    logic [15:0] exp_a, exp_b;
    logic        chk_en;
    logic        last_done, last_err;
    int          total  = 0;
    int          passed = 0;

    function automatic logic [15:0] rd(input logic [1:0] sel);
        return (sel == 2'd3) ? 16'h0 : m_reg[sel];
    endfunction

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] d,
                                       input logic [1:0] s, input logic ui);
        return {op, d, s, ui, 6'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 16'h0;
        m_flags   = 4'h0;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_op    = '0;
        exp_a     = '0;
        exp_b     = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_ready", {31'b0, instr_ready}, {31'b0, exp_ready});
            check("done", {31'b0, done}, {31'b0, exp_done});
            check("err", {31'b0, err}, {31'b0, exp_err});
            check("acc", {16'b0, acc}, {16'b0, m_reg[0]});
            check("x", {16'b0, x}, {16'b0, m_reg[1]});
            check("y", {16'b0, y}, {16'b0, m_reg[2]});
            check("flags", {28'b0, flags}, {28'b0, m_flags});
            check("alu_op", {27'b0, alu_op}, {27'b0, exp_op});
            check("alu_a", {16'b0, alu_a}, {16'b0, exp_a});
            check("alu_b", {16'b0, alu_b}, {16'b0, exp_b});
        end
    end

    // Offer one instruction, keep instr_valid high with scrambled instr/imm while
    // busy, and step the model through EXEC and WB.
    task automatic issue(input logic [15:0] ins, input logic [15:0] im);
        logic [4:0]  op;
        logic [1:0]  d, s;
        logic        ui, legal, trap;
        logic [15:0] a, b;
        logic [21:0] res;
        op = ins[15:11];
        d  = ins[10:9];
        s  = ins[8:7];
        ui = ins[6];
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        imm         = im;
        @(posedge clk);
        #1;
        instr     = 16'($urandom);
        imm       = 16'($urandom);
        a         = (op == 5'd4) ? {14'b0, d} : rd(d);
        b         = ui ? im : rd(s);
        exp_ready = 1'b0;
        exp_op    = op;
        exp_a     = a;
        exp_b     = b;
        legal     = (op <= 5'd17);
        trap      = 1'b0;
`ifdef ALU_CTRL_DIVZERO_TRAP_EN
        trap = (op == 5'd8 || op == 5'd9) && (b == 16'h0);
`endif
        res = alu_fn(op, a, b);
        @(posedge clk);
        #1;
        exp_op   = '0;
        exp_a    = '0;
        exp_b    = '0;
        exp_done = 1'b1;
        exp_err  = !legal || trap;
        if (legal && !trap) begin
            m_flags = res[19:16];
            if (op == 5'd4) begin
                if (res[21:20] != 2'd3) m_reg[res[21:20]] = res[15:0];
            end else if (op != 5'd14 && op != 5'd15 && d != 2'd3) begin
                m_reg[d] = res[15:0];
            end
        end
        last_done = done;
        last_err  = err;
        @(posedge clk);
        #1;
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_ready   = 1'b1;
        instr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_en      = 1'b0;
        rst         = 1'b1;
        instr_valid = 1'b1;
        instr       = mk(5'd0, 2'd0, 2'd0, 1'b1);
        imm         = 16'h1234;
        last_done   = 1'b0;
        last_err    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        // Valid held during reset must not be accepted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst         = 1'b0;
        instr_valid = 1'b0;
        check("reset_ready", {31'b0, instr_ready}, 32'd1);
        check("reset_flags", {28'b0, flags}, 32'h0);

        issue(mk(5'd4, 2'd1, 2'd0, 1'b1), 16'h0005);            // MOV x,#5
        check("mov_x", {16'b0, x}, 32'h0005);
        check("mov_done", {31'b0, last_done}, 32'd1);
        check("mov_acc_y", {acc, y}, 32'h0);

        issue(mk(5'd4, 2'd0, 2'd0, 1'b1), 16'h7FFF);            // MOV acc,#7FFF
        issue(mk(5'd0, 2'd0, 2'd0, 1'b1), 16'h0001);            // ADD acc,#1
        check("add_acc", {16'b0, acc}, 32'h8000);
        check("add_flags", {28'b0, flags}, 32'h9);

        issue(mk(5'd4, 2'd0, 2'd0, 1'b1), 16'h0003);            // MOV acc,#3
        issue(mk(5'd14, 2'd0, 2'd0, 1'b1), 16'h0003);           // CMP acc,#3
        check("cmp_acc", {16'b0, acc}, 32'h0003);
        check("cmp_z", {31'b0, flags[2]}, 32'd1);

        issue(mk(5'd31, 2'd0, 2'd0, 1'b1), 16'h0001);           // illegal
        check("illegal_err", {31'b0, last_err}, 32'd1);
        check("illegal_done", {31'b0, last_done}, 32'd1);
        check("illegal_flags", {28'b0, flags}, 32'h6);
        check("illegal_acc", {16'b0, acc}, 32'h0003);

        issue(mk(5'd0, 2'd2, 2'd1, 1'b0), 16'hAAAA);            // ADD y,x
        check("add_reg_y", {16'b0, y}, 32'h0005);
        issue(mk(5'd5, 2'd0, 2'd2, 1'b0), 16'h0000);            // XOR acc,y
        check("xor_acc", {16'b0, acc}, 32'h0006);

        issue(mk(5'd4, 2'd1, 2'd0, 1'b1), 16'h0010);            // MOV x,#10
        issue(mk(5'd8, 2'd1, 2'd0, 1'b1), 16'h0000);            // DIV x,#0
`ifdef ALU_CTRL_DIVZERO_TRAP_EN
        check("div0_err", {31'b0, last_err}, 32'd1);
        check("div0_x", {16'b0, x}, 32'h0010);
`else
        check("div0_err", {31'b0, last_err}, 32'd0);
        check("div0_x", {16'b0, x}, 32'hFFFF);
`endif

        issue(mk(5'd0, 2'd3, 2'd0, 1'b1), 16'h0007);            // ADD zero-reg,#7
        issue(mk(5'd4, 2'd2, 2'd0, 1'b0), 16'h0000);            // MOV y,acc
        check("mov_reg_y", {16'b0, y}, 32'h0006);
        issue(mk(5'd15, 2'd0, 2'd2, 1'b0), 16'h0000);           // TST acc,y
        issue(mk(5'd17, 2'd0, 2'd0, 1'b0), 16'h0000);           // last legal opcode
        issue(mk(5'd18, 2'd0, 2'd0, 1'b1), 16'h0001);           // first illegal opcode
        check("op18_err", {31'b0, last_err}, 32'd1);
        issue(mk(5'd1, 2'd1, 2'd0, 1'b0), 16'h0000);            // SUB x,acc
        issue(mk(5'd9, 2'd2, 2'd1, 1'b0), 16'h0000);            // remainder y by x

        // Reset during EXEC of ADD acc,#1 aborts the instruction.
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = mk(5'd0, 2'd0, 2'd0, 1'b1);
        imm         = 16'h0001;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        exp_ready   = 1'b0;
        exp_op      = 5'd0;
        exp_a       = m_reg[0];
        exp_b       = 16'h0001;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("abort_acc", {16'b0, acc}, 32'h0);
        check("abort_ready", {31'b0, instr_ready}, 32'd1);
        check("abort_done", {31'b0, done}, 32'd0);

        issue(mk(5'd4, 2'd0, 2'd0, 1'b1), 16'h0009);            // MOV acc,#9
        check("post_reset_acc", {16'b0, acc}, 32'h0009);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
